// File: rtl/spi_rx_if.sv
// Handshake bundle for spi_rx: serial inputs, byte output and status.
// The overrun flag exists only when SPI_RX_OVERRUN_EN is defined.
interface spi_rx_if;
    logic       serial_in;
    logic       serial_clock;
    logic       rd_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       frame_err;
`ifdef SPI_RX_OVERRUN_EN
    logic       overrun;
`endif

    modport master (
        input  serial_in,
        input  serial_clock,
        input  rd_en,
        output data_out,
        output data_valid,
        output busy,
        output frame_err
`ifdef SPI_RX_OVERRUN_EN
        , output overrun
`endif
    );

    modport slave (
        output serial_in,
        output serial_clock,
        output rd_en,
        input  data_out,
        input  data_valid,
        input  busy,
        input  frame_err
`ifdef SPI_RX_OVERRUN_EN
        , input overrun
`endif
    );
endinterface

// File: rtl/spi_rx.sv
// SPI byte receiver: synchronized falling-edge sampling, MSB first.
// Optional SPI_RX_OVERRUN_EN: drop new byte while one is pending, flag overrun.
module spi_rx #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_W      = 16
) (
    input  logic clk,
    input  logic rst,
    spi_rx_if.master bus
);

    typedef enum logic {
        IDLE,
        RECEIVING
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TO_MAX  = '1;
    localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);

    state_t               state;
    logic                 sclk_s1;
    logic                 sclk_s2;
    logic                 sclk_s3;
    logic                 sin_s1;
    logic                 sin_s2;
    logic                 fall;
    logic [7:0]           shift_reg;
    logic [7:0]           byte_in;
    logic [2:0]           bit_cnt;
    logic [TIMEOUT_W-1:0] tcnt;

    // Data and clock share the same depth so sin_s2 lines up with the edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            sin_s1  <= 1'b0;
            sin_s2  <= 1'b0;
        end else begin
            sclk_s1 <= bus.serial_clock;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            sin_s1  <= bus.serial_in;
            sin_s2  <= sin_s1;
        end
    end

    assign fall    = sclk_s3 & ~sclk_s2;
    assign byte_in = {shift_reg[6:0], sin_s2};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            shift_reg      <= '0;
            bit_cnt        <= '0;
            tcnt           <= '0;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.frame_err  <= 1'b0;
`ifdef SPI_RX_OVERRUN_EN
            bus.overrun    <= 1'b0;
`endif
        end else begin
            bus.frame_err <= 1'b0;
            if (bus.rd_en && bus.data_valid) begin
                bus.data_valid <= 1'b0;
`ifdef SPI_RX_OVERRUN_EN
                bus.overrun    <= 1'b0;
`endif
            end
            if (fall) begin
                shift_reg <= byte_in;
            end
            unique case (state)
                IDLE: begin
                    if (fall) begin
                        bit_cnt  <= 3'd1;
                        tcnt     <= '0;
                        bus.busy <= 1'b1;
                        state    <= RECEIVING;
                    end
                end
                RECEIVING: begin
                    if (fall) begin
                        tcnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt  <= '0;
                            bus.busy <= 1'b0;
                            state    <= IDLE;
`ifdef SPI_RX_OVERRUN_EN
                            if (bus.data_valid && !bus.rd_en) begin
                                bus.overrun <= 1'b1;
                            end else begin
                                bus.data_out   <= byte_in;
                                bus.data_valid <= 1'b1;
                            end
`else
                            bus.data_out   <= byte_in;
                            bus.data_valid <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else if (TO_EN && tcnt == TO_LAST) begin
                        bus.frame_err <= 1'b1;
                        bit_cnt       <= '0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end else if (tcnt != TO_MAX) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rx.sv
// Scoreboard bench for spi_rx: expected bytes queued at send time,
// popped when data_valid presents them.
module tb_spi_rx;
    localparam int TO = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_rx_if bus ();

    spi_rx #(
        .TIMEOUT_CYCLES(TO),
        .TIMEOUT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int         tests = 0;
    int         fails = 0;
    int         fe_cnt = 0;
    int         dv_rises = 0;
    logic       dv_q = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp;

    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) fe_cnt++;
        if (bus.data_valid === 1'b1 && dv_q !== 1'b1) dv_rises++;
        dv_q = bus.data_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic ncyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        bus.serial_in    = b;
        bus.serial_clock = 1'b1;
        ncyc(4);
        bus.serial_clock = 1'b0;
        ncyc(4);
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.data_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic accept();
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ncyc(2);
        tests++;
        if (bus.data_out !== 8'h00) begin
            fails++;
            $display("FAIL reset_data_out: got %h expected 00", bus.data_out);
        end
        tests++;
        if (bus.data_valid !== 1'b0 || bus.busy !== 1'b0 || bus.frame_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: got dv=%b busy=%b fe=%b expected 0 0 0",
                     bus.data_valid, bus.busy, bus.frame_err);
        end
`ifdef SPI_RX_OVERRUN_EN
        tests++;
        if (bus.overrun !== 1'b0) begin
            fails++;
            $display("FAIL reset_overrun: got %b expected 0", bus.overrun);
        end
`endif
        rst = 1'b0;
        ncyc(2);
    endtask

    task automatic test_single();
        logic [7:0] d;
        d = 8'hA5;
        exp_q.push_back(d);
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL single_idle_busy: got %b expected 0", bus.busy);
        end
        send_bit(d[7]);
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL single_busy_bit1: got %b expected 1", bus.busy);
        end
        for (int i = 6; i >= 1; i--) send_bit(d[i]);
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL single_busy_bit7: got %b expected 1", bus.busy);
        end
        bus.serial_in    = d[0];
        bus.serial_clock = 1'b1;
        ncyc(4);
        bus.serial_clock = 1'b0;
        ncyc(2);
        tests++;
        if (bus.data_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_early_valid: got %b expected 0 after 2 clk", bus.data_valid);
        end
        ncyc(1);
        tests++;
        if (bus.data_valid !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL single_latency: got dv=%b busy=%b expected 1 0 after 3 clk",
                     bus.data_valid, bus.busy);
        end
        exp = exp_q.pop_front();
        tests++;
        if (bus.data_out !== exp) begin
            fails++;
            $display("FAIL single_data: got %h expected %h", bus.data_out, exp);
        end
        accept();
        tests++;
        if (bus.data_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_rd_clear: got %b expected 0", bus.data_valid);
        end
        ncyc(3);
    endtask

    task automatic test_back_to_back();
        int fe0;
        int r0;
        bit ok;
        logic [7:0] pat[2];
        fe0 = fe_cnt;
        r0  = dv_rises;
        pat[0] = 8'h00;
        pat[1] = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(pat[k]);
            send_byte(pat[k]);
            wait_valid(ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL b2b_valid_timeout: got no data_valid expected 1");
            end
            exp = exp_q.pop_front();
            tests++;
            if (bus.data_out !== exp) begin
                fails++;
                $display("FAIL b2b_data: got %h expected %h", bus.data_out, exp);
            end
            accept();
        end
        tests++;
        if (dv_rises - r0 != 2 || fe_cnt != fe0) begin
            fails++;
            $display("FAIL b2b_counts: got rises=%0d fe=%0d expected 2 0",
                     dv_rises - r0, fe_cnt - fe0);
        end
        ncyc(3);
    endtask

    task automatic test_timeout();
        int fe0;
        bit ok;
        fe0 = fe_cnt;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL to_busy_partial: got %b expected 1", bus.busy);
        end
        ncyc(TO + 5);
        tests++;
        if (fe_cnt - fe0 != 1 || bus.busy !== 1'b0 || bus.data_valid !== 1'b0) begin
            fails++;
            $display("FAIL to_discard: got fe=%0d busy=%b dv=%b expected 1 0 0",
                     fe_cnt - fe0, bus.busy, bus.data_valid);
        end
        exp_q.push_back(8'h3C);
        send_byte(8'h3C);
        wait_valid(ok);
        exp = exp_q.pop_front();
        tests++;
        if (!ok || bus.data_out !== exp) begin
            fails++;
            $display("FAIL to_resync: got ok=%b data=%h expected 1 %h", ok, bus.data_out, exp);
        end
        accept();
        ncyc(3);
    endtask

    task automatic test_overrun();
`ifdef SPI_RX_OVERRUN_EN
        exp_q.push_back(8'h11);
`else
        exp_q.push_back(8'h22);
`endif
        send_byte(8'h11);
        send_byte(8'h22);
        ncyc(2);
        exp = exp_q.pop_front();
        tests++;
        if (bus.data_out !== exp || bus.data_valid !== 1'b1) begin
            fails++;
            $display("FAIL ovr_data: got %h dv=%b expected %h 1", bus.data_out, bus.data_valid, exp);
        end
`ifdef SPI_RX_OVERRUN_EN
        tests++;
        if (bus.overrun !== 1'b1) begin
            fails++;
            $display("FAIL ovr_flag: got %b expected 1", bus.overrun);
        end
`endif
        accept();
        tests++;
        if (bus.data_valid !== 1'b0) begin
            fails++;
            $display("FAIL ovr_rd_clear: got dv=%b expected 0", bus.data_valid);
        end
`ifdef SPI_RX_OVERRUN_EN
        tests++;
        if (bus.overrun !== 1'b0) begin
            fails++;
            $display("FAIL ovr_flag_clear: got %b expected 0", bus.overrun);
        end
`endif
        ncyc(3);
    endtask

    task automatic test_reset_mid();
        int fe0;
        bit ok;
        fe0 = fe_cnt;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        ncyc(1);
        tests++;
        if (bus.data_out !== 8'h00 || bus.busy !== 1'b0 || bus.data_valid !== 1'b0 ||
            bus.frame_err !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_outputs: got data=%h busy=%b dv=%b fe=%b expected 00 0 0 0",
                     bus.data_out, bus.busy, bus.data_valid, bus.frame_err);
        end
        ncyc(2);
        rst = 1'b0;
        ncyc(2);
        exp_q.push_back(8'h81);
        send_byte(8'h81);
        wait_valid(ok);
        exp = exp_q.pop_front();
        tests++;
        if (!ok || bus.data_out !== exp) begin
            fails++;
            $display("FAIL rstmid_data: got ok=%b data=%h expected 1 %h", ok, bus.data_out, exp);
        end
        tests++;
        if (fe_cnt != fe0) begin
            fails++;
            $display("FAIL rstmid_no_fe: got %0d pulses expected 0", fe_cnt - fe0);
        end
        accept();
        ncyc(3);
    endtask

    task automatic test_simul_accept();
        bit ok;
        logic [7:0] d;
        d = 8'h5A;
        exp_q.push_back(8'h99);
        send_byte(8'h99);
        wait_valid(ok);
        exp_q.push_back(d);
        for (int i = 7; i >= 1; i--) send_bit(d[i]);
        bus.serial_in    = d[0];
        bus.serial_clock = 1'b1;
        ncyc(4);
        bus.serial_clock = 1'b0;
        ncyc(2);
        exp = exp_q.pop_front();
        tests++;
        if (!ok || bus.data_out !== exp || bus.data_valid !== 1'b1) begin
            fails++;
            $display("FAIL sim_pending: got ok=%b data=%h dv=%b expected 1 %h 1",
                     ok, bus.data_out, bus.data_valid, exp);
        end
        bus.rd_en = 1'b1;
        ncyc(1);
        bus.rd_en = 1'b0;
        exp = exp_q.pop_front();
        tests++;
        if (bus.data_out !== exp || bus.data_valid !== 1'b1) begin
            fails++;
            $display("FAIL sim_load: got data=%h dv=%b expected %h 1",
                     bus.data_out, bus.data_valid, exp);
        end
`ifdef SPI_RX_OVERRUN_EN
        tests++;
        if (bus.overrun !== 1'b0) begin
            fails++;
            $display("FAIL sim_overrun: got %b expected 0", bus.overrun);
        end
`endif
        accept();
        tests++;
        if (bus.data_valid !== 1'b0) begin
            fails++;
            $display("FAIL sim_rd_clear: got %b expected 0", bus.data_valid);
        end
        ncyc(3);
    endtask

    initial begin
        rst              = 1'b1;
        bus.serial_in    = 1'b0;
        bus.serial_clock = 1'b0;
        bus.rd_en        = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_overrun();
        test_reset_mid();
        test_simul_accept();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_rx.md
Name: spi_rx

Overview:
- Serial-to-parallel SPI receive block; the receiving end of the team's SPI byte transmitter.
- Samples serial_in on each falling edge of an externally driven serial_clock and assembles bytes MSB first.
- Presents each byte on a valid/rd_en handshake to the fabric side.
- serial_clock and serial_in may be asynchronous to clk; both are synchronized internally.
- Includes an inactivity timeout that discards partial bytes and resyncs.

Parameters:
- TIMEOUT_CYCLES, 1024: clk cycles without a serial_clock falling edge, mid-byte, before the partial byte is discarded. 0 disables the timeout.
- TIMEOUT_W, 16: width of the timeout counter. TIMEOUT_CYCLES must be below 2**TIMEOUT_W.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- rst, input, 1: asynchronous, active-high reset.
- serial_in, input, 1: serial data from the transmitter.
- serial_clock, input, 1: serial clock from the transmitter; idle low.
- rd_en, input, 1: consumer accepts data_out while data_valid=1.
- data_out, output, 8: last received byte.
- data_valid, output, 1: data_out holds an unread byte.
- busy, output, 1: high while a byte is partially received.
- frame_err, output, 1: one-cycle pulse when the timeout discards a partial byte.
- overrun, output, 1: present only with SPI_RX_OVERRUN_EN.

Behaviour:
- Reset: all outputs 0; internal state cleared.
  - data_out=0x00, data_valid=0, busy=0, frame_err=0, overrun=0.
  - Synchronizer flops reset to 0; bit counter reset to 0; state IDLE.
- Reset asserted mid-byte: the partial byte is lost, with no frame_err. The first falling edge after release starts a new byte.
- Synchronization:
  - Two flop stages on both serial_clock and serial_in, with identical depth so the two stay aligned.
  - A third register on the synchronized clock supports edge detection.
  - Falling edge = previous synchronized clock 1, current synchronized clock 0.
- Timing requirements on the transmitter:
  - Minimum serial_clock high and low time: 1 clk cycle if the source is synchronous to clk, otherwise 2 clk cycles.
  - serial_in must be stable from the rising edge of serial_clock until 1 clk after the falling edge.
- Sampling: on a detected falling edge, shift_reg <= {shift_reg[6:0], sin_sync}.
- State machine, IDLE:
  - busy=0.
  - Falling edge: shift in the first bit, bit counter=1, clear the timeout counter, go to RECEIVING.
- State machine, RECEIVING:
  - busy=1.
  - Each falling edge: shift in a bit and clear the timeout counter.
  - Falling edge with bit counter=7 (eighth bit):
    - data_out <= {shift_reg[6:0], sin_sync}.
    - data_valid <= 1.
    - Bit counter <= 0, go to IDLE.
  - Falling edge with bit counter below 7: counter+1.
  - No edge: timeout counter +1, saturating.
  - Timeout counter reaches TIMEOUT_CYCLES (when TIMEOUT_CYCLES != 0):
    - Pulse frame_err for 1 cycle.
    - Bit counter <= 0, go to IDLE.
    - data_out and data_valid are unchanged.
- Latency: data_valid rises on the 3rd clk edge after serial_clock is first sampled low following the eighth bit. That is 2 synchronizer stages plus 1 register.
- Handshake:
  - rd_en with data_valid=1 clears data_valid on the next edge.
  - rd_en with data_valid=0 is ignored.
- Simultaneous events:
  - Byte completes in the same cycle as an accepting rd_en: the new byte is loaded and data_valid stays 1. This is not an overrun.
  - Byte completes while data_valid=1 and no rd_en: see Optional Feature.
- Back-to-back bytes: a falling edge arriving in the cycle after the completing edge starts the next byte. No dead time is required.
- Rising edges of serial_clock are ignored.

Optional Feature:
- Macro: SPI_RX_OVERRUN_EN.
- Defined:
  - overrun port exists.
  - A completing byte while data_valid=1 and no rd_en is dropped; data_out keeps the old byte.
  - overrun is set sticky on that drop and cleared on the edge where rd_en accepts a byte.
- Undefined:
  - No overrun port.
  - A completing byte always overwrites data_out and data_valid stays 1; the old byte is silently lost.

Test Plan:
- Send 0xA5 MSB first, 4 clk high / 4 clk low per bit:
  - data_valid rises 3 clk after the 8th falling edge with data_out=0xA5.
  - busy is high from the 1st to the 8th bit.
- Back-to-back 0x00 then 0xFF, with rd_en pulsed after each data_valid: data_out=0x00 then 0xFF, two data_valid rises, frame_err never asserted.
- Send 3 bits then idle for TIMEOUT_CYCLES+5, then send 0x3C:
  - One frame_err pulse, busy drops.
  - Next byte received as 0x3C, not shifted.
- With SPI_RX_OVERRUN_EN: send 0x11 then 0x22, no rd_en:
  - data_out=0x11 and overrun=1.
  - rd_en clears overrun and data_valid.
- Without the macro, the same stimulus gives data_out=0x22 with data_valid=1.
- Assert rst after 5 bits of 0xF0, then send 0x81: no frame_err, data_out=0x81, all outputs 0 during reset.
- Drive rd_en in the exact cycle the next byte 0x5A completes while 0x99 is pending: data_out=0x5A, data_valid stays 1, overrun stays 0.
